// File: rtl/mem_access_unit.sv
// Pipelined data-memory stage: region decode, store/load lane alignment,
// MMIO register window and an in-order tracker for up to OUTSTANDING requests.
module mem_access_unit #(
    parameter logic [63:0] MMIO_BASE   = 64'h4000_0000,
    parameter int unsigned MMIO_WORDS  = 512,
    parameter logic [63:0] MAIN_BASE   = 64'h8000_0000,
    parameter logic [63:0] MAIN_SIZE   = 64'h2000_0000,
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        req_valid_i,
    input  logic [63:0] req_addr_i,
    input  logic [1:0]  req_byte_en_i,
    input  logic        req_wr_i,
    input  logic        req_zero_extnd_i,
    input  logic [63:0] req_wr_data_i,
    output logic        req_ready_o,

    output logic        resp_valid_o,
    output logic [63:0] resp_rd_data_o,

    input  logic        data_mem_ready_i,
    output logic        data_mem_req_o,
    output logic        data_mem_wr_o,
    output logic [63:0] data_mem_addr_o,
    output logic [63:0] data_mem_wr_data_o,
    output logic [7:0]  data_mem_wr_strb_o,
    input  logic        data_mem_resp_valid_i,
    input  logic [63:0] data_mem_rd_data_i,
    output logic        data_mem_resp_ready_o,

    input  logic        flush_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_code_i,
    output logic        exc_valid_o,
    output logic [4:0]  exc_code_o
);

    // mem_access_size_t encoding carried on req_byte_en_i
    localparam logic [1:0] SIZE_BYTE   = 2'd0;
    localparam logic [1:0] SIZE_HALF   = 2'd1;
    localparam logic [1:0] SIZE_WORD   = 2'd2;
    localparam logic [1:0] SIZE_DOUBLE = 2'd3;

    localparam logic [4:0] EXC_LD_MISALIGN = 5'd4;
    localparam logic [4:0] EXC_LD_OOB      = 5'd5;
    localparam logic [4:0] EXC_ST_MISALIGN = 5'd6;
    localparam logic [4:0] EXC_ST_OOB      = 5'd7;

    localparam int unsigned IDX_W = $clog2(MMIO_WORDS);
    localparam int unsigned PTR_W = $clog2(OUTSTANDING);
    localparam logic [63:0] MMIO_LAST = MMIO_BASE + 64'(MMIO_WORDS) * 64'd8 - 64'd1;
    localparam logic [63:0] MAIN_LAST = MAIN_BASE + MAIN_SIZE - 64'd1;
    localparam logic [PTR_W:0] DEPTH  = (PTR_W+1)'(OUTSTANDING);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic [2:0]  trk_addr [OUTSTANDING];
    logic [1:0]  trk_size [OUTSTANDING];
    logic        trk_zext [OUTSTANDING];
    logic        trk_wr   [OUTSTANDING];
    logic        trk_mmio [OUTSTANDING];
    logic        trk_kill [OUTSTANDING];
    logic [63:0] trk_data [OUTSTANDING];
    logic [OUTSTANDING-1:0] trk_live;

    logic [63:0] mmio_regs [MMIO_WORDS];
    logic [IDX_W-1:0] mmio_idx;

    logic        is_mmio;
    logic        is_main;
    logic        is_oob;
    logic        misaligned;
    logic        fire;
    logic        local_exc;
    logic [4:0]  local_code;
    logic        accept;
    logic        acc_main;
    logic        acc_mmio;
    logic [2:0]  off;
    logic [63:0] st_data;
    logic [7:0]  st_strb;

    logic        head_valid;
    logic        head_mmio;
    logic        pop;
    logic [63:0] ld_src;
    logic [63:0] ld_shift;
    logic        ld_zext;
    logic [63:0] ld_data;

    // ---------------- request decode ----------------
    assign is_mmio = (req_addr_i >= MMIO_BASE) && (req_addr_i <= MMIO_LAST);
    assign is_main = (req_addr_i >= MAIN_BASE) && (req_addr_i <= MAIN_LAST);
    assign is_oob  = ~is_mmio & ~is_main;
    assign off     = req_addr_i[2:0];

    always_comb begin
        misaligned = 1'b0;
        case (req_byte_en_i)
            SIZE_HALF:   misaligned = off[0];
            SIZE_WORD:   misaligned = |off[1:0];
            SIZE_DOUBLE: misaligned = |off;
            default:     misaligned = 1'b0;
        endcase
    end

    assign req_ready_o = (count < DEPTH) & data_mem_ready_i;
    assign fire        = req_valid_i & req_ready_o;

    always_comb begin
        local_exc  = 1'b0;
        local_code = '0;
        if (fire) begin
            if (is_oob) begin
                local_exc  = 1'b1;
                local_code = req_wr_i ? EXC_ST_OOB : EXC_LD_OOB;
            end else if (misaligned) begin
                local_exc  = 1'b1;
                local_code = req_wr_i ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
            end
        end
    end

    assign exc_valid_o = exc_valid_i | local_exc;
    assign exc_code_o  = exc_valid_i ? exc_code_i : local_code;

    assign accept   = fire & ~flush_i & ~exc_valid_o;
    assign acc_main = accept & is_main;
    assign acc_mmio = accept & is_mmio;

    // ---------------- store lane alignment ----------------
    always_comb begin
        st_data = '0;
        st_strb = '0;
        case (req_byte_en_i)
            SIZE_BYTE: begin
                st_data = {8{req_wr_data_i[7:0]}};
                st_strb = 8'h01 << off;
            end
            SIZE_HALF: begin
                st_data = {4{req_wr_data_i[15:0]}};
                st_strb = 8'h03 << {off[2:1], 1'b0};
            end
            SIZE_WORD: begin
                st_data = {2{req_wr_data_i[31:0]}};
                st_strb = 8'h0F << {off[2], 2'b00};
            end
            default: begin
                st_data = req_wr_data_i;
                st_strb = 8'hFF;
            end
        endcase
    end

    assign data_mem_req_o     = acc_main;
    assign data_mem_wr_o      = acc_main & req_wr_i;
    assign data_mem_addr_o    = acc_main ? {req_addr_i[63:3], 3'b000} : '0;
    assign data_mem_wr_data_o = (acc_main & req_wr_i) ? st_data : '0;
    assign data_mem_wr_strb_o = (acc_main & req_wr_i) ? st_strb : '0;

    // ---------------- MMIO register window (not reset) ----------------
    assign mmio_idx = req_addr_i[3 +: IDX_W];

    always_ff @(posedge clk) begin
        if (acc_mmio && req_wr_i) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (st_strb[b]) begin
                    mmio_regs[mmio_idx][b*8 +: 8] <= st_data[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- tracker head / response path ----------------
    assign head_valid            = (count != '0);
    assign head_mmio             = trk_mmio[rd_ptr];
    assign data_mem_resp_ready_o = head_valid & ~head_mmio;
    assign pop                   = head_valid & (head_mmio | data_mem_resp_valid_i);
    assign resp_valid_o          = pop & ~trk_kill[rd_ptr];

    always_comb begin
        ld_src   = head_mmio ? trk_data[rd_ptr] : data_mem_rd_data_i;
        ld_shift = ld_src >> {trk_addr[rd_ptr], 3'b000};
        ld_zext  = trk_zext[rd_ptr];
        case (trk_size[rd_ptr])
            SIZE_BYTE:
                ld_data = ld_zext ? {56'd0, ld_shift[7:0]}
                                  : {{56{ld_shift[7]}}, ld_shift[7:0]};
            SIZE_HALF:
                ld_data = ld_zext ? {48'd0, ld_shift[15:0]}
                                  : {{48{ld_shift[15]}}, ld_shift[15:0]};
            SIZE_WORD:
                ld_data = ld_zext ? {32'd0, ld_shift[31:0]}
                                  : {{32{ld_shift[31]}}, ld_shift[31:0]};
            default:
                ld_data = ld_src;
        endcase
    end

    assign resp_rd_data_o = (resp_valid_o & ~trk_wr[rd_ptr]) ? ld_data : '0;

    // An entry is live when its distance from rd_ptr is below count.
    always_comb begin
        trk_live = '0;
        for (int unsigned i = 0; i < OUTSTANDING; i++) begin
            trk_live[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
        end
    end

    // ---------------- tracker state ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                trk_addr[i] <= '0;
                trk_size[i] <= '0;
                trk_zext[i] <= 1'b0;
                trk_wr[i]   <= 1'b0;
                trk_mmio[i] <= 1'b0;
                trk_kill[i] <= 1'b0;
                trk_data[i] <= '0;
            end
        end else begin
            if (accept) begin
                trk_addr[wr_ptr] <= off;
                trk_size[wr_ptr] <= req_byte_en_i;
                trk_zext[wr_ptr] <= req_zero_extnd_i;
                trk_wr[wr_ptr]   <= req_wr_i;
                trk_mmio[wr_ptr] <= is_mmio;
                trk_kill[wr_ptr] <= 1'b0;
                trk_data[wr_ptr] <= (is_mmio && !req_wr_i) ? mmio_regs[mmio_idx] : '0;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // flush never coincides with a push, so only older entries are marked
            if (flush_i) begin
                for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                    if (trk_live[i]) begin
                        trk_kill[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed vectors, expected responses
// queued at issue and popped by an independent response monitor.
module tb_mem_access_unit;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid_i = 1'b0;
    logic [63:0] req_addr_i = '0;
    logic [1:0]  req_byte_en_i = '0;
    logic        req_wr_i = 1'b0;
    logic        req_zero_extnd_i = 1'b0;
    logic [63:0] req_wr_data_i = '0;
    logic        req_ready_o;
    logic        resp_valid_o;
    logic [63:0] resp_rd_data_o;
    logic        data_mem_ready_i = 1'b1;
    logic        data_mem_req_o;
    logic        data_mem_wr_o;
    logic [63:0] data_mem_addr_o;
    logic [63:0] data_mem_wr_data_o;
    logic [7:0]  data_mem_wr_strb_o;
    logic        data_mem_resp_valid_i = 1'b0;
    logic [63:0] data_mem_rd_data_i = '0;
    logic        data_mem_resp_ready_o;
    logic        flush_i = 1'b0;
    logic        exc_valid_i = 1'b0;
    logic [4:0]  exc_code_i = '0;
    logic        exc_valid_o;
    logic [4:0]  exc_code_o;

    always #5 clk = ~clk;

    mem_access_unit #(
        .MMIO_BASE  (64'h4000_0000),
        .MMIO_WORDS (512),
        .MAIN_BASE  (64'h8000_0000),
        .MAIN_SIZE  (64'h2000_0000),
        .OUTSTANDING(4)
    ) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .req_valid_i          (req_valid_i),
        .req_addr_i           (req_addr_i),
        .req_byte_en_i        (req_byte_en_i),
        .req_wr_i             (req_wr_i),
        .req_zero_extnd_i     (req_zero_extnd_i),
        .req_wr_data_i        (req_wr_data_i),
        .req_ready_o          (req_ready_o),
        .resp_valid_o         (resp_valid_o),
        .resp_rd_data_o       (resp_rd_data_o),
        .data_mem_ready_i     (data_mem_ready_i),
        .data_mem_req_o       (data_mem_req_o),
        .data_mem_wr_o        (data_mem_wr_o),
        .data_mem_addr_o      (data_mem_addr_o),
        .data_mem_wr_data_o   (data_mem_wr_data_o),
        .data_mem_wr_strb_o   (data_mem_wr_strb_o),
        .data_mem_resp_valid_i(data_mem_resp_valid_i),
        .data_mem_rd_data_i   (data_mem_rd_data_i),
        .data_mem_resp_ready_o(data_mem_resp_ready_o),
        .flush_i              (flush_i),
        .exc_valid_i          (exc_valid_i),
        .exc_code_i           (exc_code_i),
        .exc_valid_o          (exc_valid_o),
        .exc_code_o           (exc_code_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Response monitor: every resp_valid_o pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && resp_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got %h, expected no response", resp_rd_data_o);
            end else begin
                check("resp_data", resp_rd_data_o, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [63:0] addr, input logic [1:0] sz, input logic wr,
                         input logic zx, input logic [63:0] d);
        @(posedge clk);
        #1;
        req_valid_i = 1'b1;
        req_addr_i = addr;
        req_byte_en_i = sz;
        req_wr_i = wr;
        req_zero_extnd_i = zx;
        req_wr_data_i = d;
        flush_i = 1'b0;
        exc_valid_i = 1'b0;
        data_mem_resp_valid_i = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        flush_i = 1'b0;
        exc_valid_i = 1'b0;
        data_mem_resp_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d responses outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [63:0] ld_addr [4] = '{64'h8000_0010, 64'h8000_0022, 64'h8000_0035, 64'h8000_0044};
    logic [1:0]  ld_size [4] = '{SZ_D, SZ_H, SZ_B, SZ_W};
    logic        ld_zx   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] mem_rd  [4] = '{64'h1122_3344_5566_7788, 64'h0000_0000_8001_0000,
                                 64'h0000_F000_0000_0000, 64'h8765_4321_0000_0000};
    logic [63:0] ld_exp  [4] = '{64'h1122_3344_5566_7788, 64'hFFFF_FFFF_FFFF_8001,
                                 64'h0000_0000_0000_00F0, 64'hFFFF_FFFF_8765_4321};

    logic [63:0] ex_addr [5] = '{64'h4000_0002, 64'h0000_1000, 64'h0000_0003,
                                 64'h8000_0001, 64'h4000_0004};
    logic [1:0]  ex_size [5] = '{SZ_W, SZ_D, SZ_H, SZ_H, SZ_W};
    logic        ex_wr   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        ex_in   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [4:0]  ex_code [5] = '{5'd4, 5'd7, 5'd5, 5'd6, 5'd2};

    logic [63:0] wd;
    logic        mmio_acc;

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("rst_resp_valid", resp_valid_o, 1'b0);
        check("rst_resp_data", resp_rd_data_o, 64'd0);
        check_bit("rst_mem_req", data_mem_req_o, 1'b0);
        check_bit("rst_mem_resp_ready", data_mem_resp_ready_o, 1'b0);
        check("rst_mem_addr", data_mem_addr_o, 64'd0);
        check("rst_mem_strb", 64'(data_mem_wr_strb_o), 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // MMIO SW, LW, LWU back to back
        drive(64'h4000_0004, SZ_W, 1'b1, 1'b0, 64'h0000_0000_DEAD_BEEF);
        exp_q.push_back(64'd0);
        @(negedge clk);
        check_bit("mmio_sw_ready", req_ready_o, 1'b1);
        check_bit("mmio_sw_no_memreq", data_mem_req_o, 1'b0);
        drive(64'h4000_0004, SZ_W, 1'b0, 1'b0, 64'd0);
        exp_q.push_back(64'hFFFF_FFFF_DEAD_BEEF);
        @(negedge clk);
        check_bit("mmio_sw_latency", resp_valid_o, 1'b1);
        drive(64'h4000_0004, SZ_W, 1'b0, 1'b1, 64'd0);
        exp_q.push_back(64'h0000_0000_DEAD_BEEF);
        @(negedge clk);
        check_bit("mmio_lw_latency", resp_valid_o, 1'b1);
        idle();
        @(negedge clk);
        check_bit("mmio_lwu_latency", resp_valid_o, 1'b1);
        wait_drain("mmio_drain");

        // SB to main memory
        drive(64'h8000_0003, SZ_B, 1'b1, 1'b0, 64'h0000_0000_0000_00A5);
        exp_q.push_back(64'd0);
        @(negedge clk);
        check_bit("sb_req", data_mem_req_o, 1'b1);
        check_bit("sb_wr", data_mem_wr_o, 1'b1);
        check("sb_addr", data_mem_addr_o, 64'h8000_0000);
        check("sb_strb", 64'(data_mem_wr_strb_o), 64'h08);
        wd = data_mem_wr_data_o;
        check("sb_lane", {56'd0, wd[31:24]}, 64'hA5);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        data_mem_resp_valid_i = 1'b1;
        data_mem_rd_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        check_bit("sb_resp_ready", data_mem_resp_ready_o, 1'b1);
        idle();
        wait_drain("sb_drain");

        // Fill the tracker with four main loads, then an MMIO load
        for (int i = 0; i < 4; i++) begin
            drive(ld_addr[i], ld_size[i], 1'b0, ld_zx[i], 64'd0);
            exp_q.push_back(ld_exp[i]);
            @(negedge clk);
            check("fill_addr", data_mem_addr_o, {ld_addr[i][63:3], 3'b000});
        end
        drive(64'h4000_0004, SZ_W, 1'b0, 1'b1, 64'd0);
        exp_q.push_back(64'h0000_0000_DEAD_BEEF);
        @(negedge clk);
        check_bit("full_ready", req_ready_o, 1'b0);
        mmio_acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (mmio_acc) req_valid_i = 1'b0;
            data_mem_resp_valid_i = 1'b1;
            data_mem_rd_data_i = mem_rd[i];
            @(negedge clk);
            if (i == 0) check_bit("full_no_bypass", req_ready_o, 1'b0);
            if (req_valid_i && req_ready_o) mmio_acc = 1'b1;
        end
        idle();
        check_bit("full_mmio_accepted", mmio_acc, 1'b1);
        wait_drain("full_drain");

        // Flush with a main load and an MMIO load in flight; flushed SW must not write
        drive(64'h8000_0008, SZ_D, 1'b0, 1'b0, 64'd0);
        drive(64'h4000_0004, SZ_W, 1'b0, 1'b1, 64'd0);
        drive(64'h4000_0004, SZ_W, 1'b1, 1'b0, 64'h0000_0000_1234_5678);
        flush_i = 1'b1;
        @(negedge clk);
        check_bit("flush_cycle_resp", resp_valid_o, 1'b0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        req_valid_i = 1'b0;
        data_mem_resp_valid_i = 1'b1;
        data_mem_rd_data_i = 64'h1;
        @(negedge clk);
        check_bit("flush_resp_ready", data_mem_resp_ready_o, 1'b1);
        check_bit("flush_main_silent", resp_valid_o, 1'b0);
        @(posedge clk);
        #1 data_mem_resp_valid_i = 1'b0;
        @(negedge clk);
        check_bit("flush_mmio_silent", resp_valid_o, 1'b0);
        idle();
        @(negedge clk);
        check_bit("flush_empty_ready", data_mem_resp_ready_o, 1'b0);
        drive(64'h4000_0004, SZ_W, 1'b0, 1'b1, 64'd0);
        exp_q.push_back(64'h0000_0000_DEAD_BEEF);
        idle();
        @(negedge clk);
        check_bit("flush_then_mmio_latency", resp_valid_o, 1'b1);
        wait_drain("flush_drain");

        // Exceptions and priority; none may have side effects
        for (int i = 0; i < 5; i++) begin
            drive(ex_addr[i], ex_size[i], ex_wr[i], 1'b0, 64'h0000_0000_0BAD_F00D);
            exc_valid_i = ex_in[i];
            exc_code_i = 5'd2;
            @(negedge clk);
            check_bit("exc_valid", exc_valid_o, 1'b1);
            check("exc_code", 64'(exc_code_o), 64'(ex_code[i]));
            check_bit("exc_no_memreq", data_mem_req_o, 1'b0);
        end
        idle();
        @(negedge clk);
        check_bit("exc_idle_clear", exc_valid_o, 1'b0);
        drive(64'h4000_0004, SZ_W, 1'b0, 1'b1, 64'd0);
        exp_q.push_back(64'h0000_0000_DEAD_BEEF);
        idle();
        wait_drain("exc_drain");

        // Reset with three main loads in flight
        for (int i = 0; i < 3; i++) begin
            drive(64'h8000_0000 + 64'(8 * i), SZ_D, 1'b0, 1'b0, 64'd0);
        end
        idle();
        @(negedge clk);
        #2;
        resetn = 1'b0;
        data_mem_resp_valid_i = 1'b1;
        data_mem_rd_data_i = 64'h5;
        #1;
        check_bit("arst_resp_valid", resp_valid_o, 1'b0);
        check_bit("arst_resp_ready", data_mem_resp_ready_o, 1'b0);
        check_bit("arst_mem_req", data_mem_req_o, 1'b0);
        check("arst_resp_data", resp_rd_data_o, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        data_mem_resp_valid_i = 1'b0;
        drive(64'h4000_0004, SZ_W, 1'b0, 1'b0, 64'd0);
        exp_q.push_back(64'hFFFF_FFFF_DEAD_BEEF);
        idle();
        @(negedge clk);
        check_bit("post_reset_latency", resp_valid_o, 1'b1);
        wait_drain("post_reset_drain");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Pipelined successor to the single-outstanding memory stage. It sits between the execute stage and the data-memory port and decodes MMIO, main-memory and out-of-bounds regions from parameters. It aligns stores with byte strobes and aligns, sign-extends or zero-extends loads. It keeps up to OUTSTANDING requests in flight, and an in-order tracker queue returns MMIO and main-memory responses strictly in request order.

## Interface
- MMIO_BASE, 64'h4000_0000, base of the MMIO register window.
- MMIO_WORDS, 512, number of 64-bit MMIO registers; power of two, ≥2.
- MAIN_BASE, 64'h8000_0000, base of main memory.
- MAIN_SIZE, 64'h2000_0000, main-memory size in bytes.
- OUTSTANDING, 4, tracker depth; power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid_i / req_addr_i[63:0] / req_byte_en_i (mem_access_size_t) / req_wr_i / req_zero_extnd_i / req_wr_data_i[63:0]  in  request from the datapath.
- req_ready_o  out  1  `(count < OUTSTANDING) & data_mem_ready_i`.
- resp_valid_o  out  1  response to the datapath; the datapath is always ready.
- resp_rd_data_o  out  64  aligned and extended load data; 0 for stores.
- data_mem_ready_i  in  1  main memory can accept a request.
- data_mem_req_o / data_mem_wr_o  out  1  main-memory request and write flag.
- data_mem_addr_o  out  64  `{req_addr_i[63:3], 3'b0}`.
- data_mem_wr_data_o  out  64  lane-aligned store data.
- data_mem_wr_strb_o  out  8  byte strobes.
- data_mem_resp_valid_i / data_mem_rd_data_i[63:0]  in  main-memory response; one per request, in order.
- data_mem_resp_ready_o  out  1  `head valid & ~head.is_mmio`.
- flush_i  in  1  squashes the incoming request and all in-flight responses.
- exc_valid_i / exc_code_i[4:0]  in  upstream exception.
- exc_valid_o / exc_code_o[4:0]  out  merged exception; combinational.

## Operation
- Region decode:
  - mmio: `MMIO_BASE ≤ addr ≤ MMIO_BASE+8*MMIO_WORDS-1`.
  - main: `MAIN_BASE ≤ addr ≤ MAIN_BASE+MAIN_SIZE-1`.
  - Any other address is out of bounds (oob).
- Misalignment rules:
  - HALF_WORD: `addr[0]`.
  - WORD: `|addr[1:0]`.
  - DOUBLE_WORD: `|addr[2:0]`.
  - BYTE is never misaligned.
- Exception codes: oob store = 7, oob load = 5, misaligned store = 6, misaligned load = 4.
- Exception priority:
  - oob beats misaligned.
  - exc_valid_i/exc_code_i beat both.
  - Local exceptions are qualified by `req_valid_i & req_ready_o`.
- accept = `req_valid_i & req_ready_o & ~flush_i & ~exc_valid_o`. Excepting or flushed requests have no side effects.
- Store alignment: data is replicated into its byte lane(s) and the strobe marks only those bytes. DOUBLE_WORD uses strobe 8'hFF.
- Main-memory accept:
  - data_mem_req_o is driven the same cycle.
  - data_mem_wr_data_o and data_mem_wr_strb_o are aligned; both are 0 for loads.
  - All data_mem_* request outputs are 0 when there is no accept.
- MMIO accept:
  - A store writes the strobed bytes of register `addr[3+log2(MMIO_WORDS)-1:3]` at the edge.
  - A load captures the register into the tracker entry at the edge.
  - MMIO register contents are not reset.
- Tracker: circular FIFO with wr_ptr, rd_ptr and count.
  - Entry fields: {addr[2:0], size, zext, wr, is_mmio, kill, data[63:0]}.
  - Every accept pushes one entry.
- Retire of the head entry:
  - An MMIO head retires in the cycle it is at the head, no earlier than the cycle after its push.
  - A main-memory head retires in the cycle `data_mem_resp_valid_i & data_mem_resp_ready_o`.
  - On retire the entry pops, and resp_valid_o = `~kill`.
- Load data source is `head.is_mmio ? head.data : data_mem_rd_data_i`, aligned by head.addr/size and extended unless zext. Store responses return 0.
- flush_i sets kill on every valid entry at the edge.
  - Killed main-memory entries still absorb their memory responses.
  - Killed MMIO entries pop silently.
  - MMIO stores already performed are not undone.
- resp_valid_o is not gated by exc_valid_i.

## Timing
- Reset values:
  - count, wr_ptr, rd_ptr = 0; all tracker fields = 0.
  - resp_valid_o, data_mem_req_o, data_mem_wr_o, data_mem_resp_ready_o = 0.
  - resp_rd_data_o, data_mem_addr_o, data_mem_wr_data_o, data_mem_wr_strb_o = 0.
- If reset is asserted mid-operation, all in-flight entries are discarded. Late memory responses are not consumed, because ready is 0.
- Throughput: one accept per cycle.
- Latency: MMIO response 1 cycle after accept when the tracker is empty. A main-memory response is combinational from data_mem_resp_valid_i.
- Full: when count == OUTSTANDING, req_ready_o = 0 even if a pop occurs in the same cycle; there is no bypass.
- Simultaneous push and pop leave count unchanged. Pointers wrap modulo OUTSTANDING.
- A flush arriving in the same cycle as a retire:
  - The retiring entry still reports resp_valid_o = `~kill_old`.
  - The kill applies to the entries remaining after the edge.

## Test plan
- MMIO SW 0xDEADBEEF @0x4000_0004, then LW @0x4000_0004 → store response 1 cycle after its accept (rd 0); load response the following cycle with rd 0xFFFF_FFFF_DEAD_BEEF. Then LWU → 0x0000_0000_DEAD_BEEF.
- SB 0xA5 @0x8000_0003 → data_mem_addr_o 0x8000_0000, strb 8'h08, wr_data[31:24] = 0xA5, all in the accept cycle.
- Four main loads with memory responses withheld, then an MMIO load → req_ready_o low on the 5th request. After the responses are released, the five resp_valid_o pulses arrive in order, and the MMIO load completes last.
- Main load in flight, then MMIO load, then flush_i → no resp_valid_o for either. The memory response is still consumed (resp_ready high) and count returns to 0.
- LW @0x4000_0002 → exc 4. SD @0x1000 → exc 7. Misaligned oob LH @0x3 → exc 5. exc_valid_i with code 2 overrides and yields code 2. None of these has any side effect.
- Reset asserted with 3 entries in flight → all outputs 0 asynchronously. After release, the first MMIO load round-trips correctly.
